// File: rtl/transmitter_serializer_pkg.sv
// Frame format and FSM encodings shared by the UART transmit and receive paths,
// so both ends of the link agree on state numbering and line levels.
package transmitter_serializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } tx_state_t;

endpackage

// File: rtl/transmitter_bit_counter.sv
// Data-bit index for the transmit path; flags when the last data bit of the
// frame is on the line. Mirrors the receiver-side bit counter.
module transmitter_bit_counter #(
  parameter int DATA_WIDTH        = 8,
  parameter int BIT_COUNTER_WIDTH = 3
) (
  input  logic i_clock,
  input  logic i_resetL,
  input  logic i_clear,
  input  logic i_advance,
  output logic o_equal_MSB
);

  logic [BIT_COUNTER_WIDTH-1:0] bit_index;

  always_ff @(posedge i_clock) begin
    if (!i_resetL)      bit_index <= '0;
    else if (i_clear)   bit_index <= '0;
    else if (i_advance) bit_index <= bit_index + 1'b1;
  end

  // Full-width compare: the index wraps modulo 2^BIT_COUNTER_WIDTH.
  assign o_equal_MSB = (bit_index == BIT_COUNTER_WIDTH'(DATA_WIDTH - 1));

endmodule

// File: rtl/transmitter_serializer.sv
// UART transmit path: takes a byte over valid/ready and sends one frame
// (start low, data LSB first, stop high) with an internal baud divider.
import transmitter_serializer_pkg::*;

module transmitter_serializer #(
  parameter int DATA_WIDTH         = 8,
  parameter int BIT_COUNTER_WIDTH  = 3,
  parameter int CLOCKS_PER_BIT     = 16,
  parameter int BAUD_COUNTER_WIDTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_resetL,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [1:0]            o_state
);

  localparam logic [BAUD_COUNTER_WIDTH-1:0] BAUD_LAST = BAUD_COUNTER_WIDTH'(CLOCKS_PER_BIT - 1);
  localparam logic [BAUD_COUNTER_WIDTH-1:0] BAUD_ONE  = BAUD_COUNTER_WIDTH'(1);

  tx_state_t                     state, next_state;
  logic [BAUD_COUNTER_WIDTH-1:0] baud_count, baud_next;
  logic [DATA_WIDTH-1:0]         shift_reg, shift_next;
  logic                          tx_reg, tx_next;
  logic                          bit_end, accept, equal_msb, advance;

  // Handshake: a byte is taken at a rising edge where i_valid && o_ready;
  // o_ready does not depend on i_valid, and i_valid while not ready is dropped.
  assign bit_end = (state != IDLE) && (baud_count == BAUD_LAST);
  assign o_ready = (state == IDLE) || ((state == STOP) && bit_end);
  assign accept  = i_valid && o_ready;
  assign advance = (state == DATA) && bit_end && !equal_msb;

  transmitter_bit_counter #(
    .DATA_WIDTH        (DATA_WIDTH),
    .BIT_COUNTER_WIDTH (BIT_COUNTER_WIDTH)
  ) u_bit_counter (
    .i_clock     (i_clock),
    .i_resetL    (i_resetL),
    .i_clear     (accept),
    .i_advance   (advance),
    .o_equal_MSB (equal_msb)
  );

  always_comb begin
    next_state = state;
    shift_next = shift_reg;
    baud_next  = baud_count;
    tx_next    = IDLE_LEVEL;

    case (state)
      IDLE:    if (accept) next_state = START;
      START:   if (bit_end) next_state = DATA;
      DATA:    if (bit_end && equal_msb) next_state = STOP;
      STOP:    if (bit_end) next_state = accept ? START : IDLE;
      default: next_state = IDLE;
    endcase

    if (accept)       shift_next = i_data;
    else if (advance) shift_next = shift_reg >> 1;

    if (accept || (state == IDLE) || bit_end) baud_next = '0;
    else                                      baud_next = baud_count + BAUD_ONE;

    // The line is registered from the next state so it changes with the state.
    case (next_state)
      IDLE:    tx_next = IDLE_LEVEL;
      START:   tx_next = START_LEVEL;
      DATA:    tx_next = shift_next[0];
      STOP:    tx_next = STOP_LEVEL;
      default: tx_next = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_resetL) begin
      state      <= IDLE;
      baud_count <= '0;
      shift_reg  <= '0;
      tx_reg     <= IDLE_LEVEL;
    end else begin
      state      <= next_state;
      baud_count <= baud_next;
      shift_reg  <= shift_next;
      tx_reg     <= tx_next;
    end
  end

  assign o_tx    = tx_reg;
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == STOP) && bit_end;
  assign o_state = state;

endmodule

// File: tb/tb_transmitter_serializer.sv
// Directed bench for transmitter_serializer with DATA_WIDTH=8, CLOCKS_PER_BIT=4.
module tb_transmitter_serializer;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int FRAME_CYCLES = (DW + 2) * CPB;

  logic          i_clock;
  logic          i_resetL;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready, o_tx, o_busy, o_done;
  logic [1:0]    o_state;

  int checks = 0;
  int errors = 0;

  transmitter_serializer #(
    .DATA_WIDTH         (DW),
    .BIT_COUNTER_WIDTH  (3),
    .CLOCKS_PER_BIT     (CPB),
    .BAUD_COUNTER_WIDTH (4)
  ) dut (
    .i_clock  (i_clock),
    .i_resetL (i_resetL),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_tx     (o_tx),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_state  (o_state)
  );

  // clock / reset
  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"},    32'(o_tx),    32'd1);
    check({tag, "_ready"}, 32'(o_ready), 32'd1);
    check({tag, "_busy"},  32'(o_busy),  32'd0);
    check({tag, "_done"},  32'(o_done),  32'd0);
    check({tag, "_state"}, 32'(o_state), 32'd0);
  endtask

  // Drive a request at a falling edge; it is accepted at the next rising edge.
  task automatic send(input logic [DW-1:0] d, input logic keep_valid);
    @(negedge i_clock);
    i_data  = d;
    i_valid = 1'b1;
    @(posedge i_clock);
    #1;
    if (!keep_valid) i_valid = 1'b0;
  endtask

  // Checks the frame cycle by cycle starting with the cycle after acceptance.
  // mode 1: toggle i_data each cycle; mode 2: offer 0xFF while busy in DATA.
  // abort_at > 0: assert reset after checking that frame cycle.
  task automatic run_frame(input logic [DW-1:0] d, input int mode, input int abort_at);
    logic [DW+1:0] frame;
    int b;
    frame = {1'b1, d, 1'b0};
    for (int c = 1; c <= FRAME_CYCLES; c++) begin
      @(negedge i_clock);
      b = (c - 1) / CPB;
      check($sformatf("tx_c%0d", c),    32'(o_tx),    32'(frame[b]));
      check($sformatf("busy_c%0d", c),  32'(o_busy),  32'd1);
      check($sformatf("done_c%0d", c),  32'(o_done),  32'(c == FRAME_CYCLES));
      check($sformatf("ready_c%0d", c), 32'(o_ready), 32'(c == FRAME_CYCLES));
      check($sformatf("state_c%0d", c), 32'(o_state),
            (b == 0) ? 32'd1 : (b == DW + 1) ? 32'd3 : 32'd2);
      if (mode == 1) i_data = ~i_data;
      if (mode == 2 && c == 12) begin i_data = 8'hFF; i_valid = 1'b1; end
      if (mode == 2 && c == 20) i_valid = 1'b0;
      if (c == abort_at) begin
        i_resetL = 1'b0;
        i_valid  = 1'b1;
        i_data   = 8'h5A;
        @(negedge i_clock);
        check_idle("abort_a");
        i_valid  = 1'b0;
        i_resetL = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge i_clock);
          check_idle($sformatf("abort_idle%0d", k));
        end
        return;
      end
    end
  endtask

  initial begin
    i_resetL = 1'b0;
    i_valid  = 1'b0;
    i_data   = '0;

    // Reset held for 3 cycles.
    repeat (3) @(negedge i_clock);
    check_idle("reset");
    i_resetL = 1'b1;
    @(negedge i_clock);
    check_idle("post_reset");

    // Single frame 0x55, then the line returns to idle.
    send(8'h55, 1'b0);
    run_frame(8'h55, 0, 0);
    @(negedge i_clock);
    check_idle("after_55");

    // Back-to-back 0xA5 then 0x3C with i_valid held.
    send(8'hA5, 1'b1);
    i_data = 8'h3C;
    run_frame(8'hA5, 0, 0);
    @(posedge i_clock);
    #1;
    i_valid = 1'b0;
    run_frame(8'h3C, 0, 0);
    @(negedge i_clock);
    check_idle("after_3c");

    // 0xFF offered while 0x0F is in DATA is dropped.
    send(8'h0F, 1'b0);
    run_frame(8'h0F, 2, 0);
    repeat (3) begin
      @(negedge i_clock);
      check_idle("after_0f");
    end

    // Reset at cycle 17 of 0x81, then a clean resend.
    send(8'h81, 1'b0);
    run_frame(8'h81, 0, 17);
    send(8'h81, 1'b0);
    run_frame(8'h81, 0, 0);
    @(negedge i_clock);
    check_idle("after_81");

    // i_data toggling after acceptance of 0xC3.
    send(8'hC3, 1'b0);
    run_frame(8'hC3, 1, 0);
    @(negedge i_clock);
    check_idle("after_c3");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/transmitter_serializer.md
# transmitter_serializer

UART transmit path: accepts a parallel byte through a ready/valid handshake and serializes it onto `o_tx` as one frame: 1 start bit (low), DATA_WIDTH data bits LSB first, 1 stop bit (high). It sits opposite the receiver in the CPLD UART datapath and uses the same frame format and bit-index convention. It also contains its own baud divider, a control FSM, a shift register and a bit counter.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `BIT_COUNTER_WIDTH`, 3: bit-index width; must satisfy 2^BIT_COUNTER_WIDTH >= DATA_WIDTH.
- `CLOCKS_PER_BIT`, 16: `i_clock` cycles per serial bit; must be >= 2.
- `BAUD_COUNTER_WIDTH`, 4: baud counter width; must satisfy 2^BAUD_COUNTER_WIDTH >= CLOCKS_PER_BIT.

- `i_clock`  in  1  sole clock; all state updates on its rising edge.
- `i_resetL`  in  1  reset, synchronous, active-low.
- `i_data`  in  DATA_WIDTH  byte to send; sampled only on acceptance.
- `i_valid`  in  1  request to send `i_data`.
- `o_ready`  out  1  block can accept a byte this cycle.
- `o_tx`  out  1  serial line, registered; idles high.
- `o_busy`  out  1  frame in progress (state != IDLE).
- `o_done`  out  1  one-cycle pulse on the last cycle of the stop bit.

## Operation
- **FSM states:** IDLE, START, DATA, STOP.
- **Acceptance:** occurs when `i_valid & o_ready` at a rising edge.
  - On acceptance, `i_data` loads into the shift register, the bit index clears to 0, the baud counter clears to 0, and the state moves to START.
- **`o_ready`:** high in IDLE, and also high in STOP during its final baud cycle. This allows gapless back-to-back frames. Low otherwise.
- **`i_valid` when not ready:** ignored. There is no queueing and no error flag.
- **Baud counter:** counts 0..CLOCKS_PER_BIT-1 in START, DATA and STOP, then wraps to 0. The bit-end strobe fires when the count equals CLOCKS_PER_BIT-1. The counter is held at 0 in IDLE.
- **START:** `o_tx`=0. On bit-end, go to DATA.
- **DATA:** `o_tx`=shift register bit 0.
  - On bit-end with bit index != DATA_WIDTH-1: shift right by 1 and increment the bit index.
  - On bit-end with bit index == DATA_WIDTH-1: go to STOP.
- **STOP:** `o_tx`=1. On bit-end, `o_done`=1 for that cycle. Then:
  - if acceptance occurs in the same cycle, go directly to START with the new byte;
  - otherwise go to IDLE.
- **Bit index:** increments modulo 2^BIT_COUNTER_WIDTH. The compare against DATA_WIDTH-1 uses full counter width.
- **Data stability:** changes on `i_data` after acceptance do not affect the frame in flight.

## Timing
- **Reset values** (when `i_resetL`=0 at an edge): state IDLE, `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_done`=0, all counters 0, shift register 0.
- **Reset mid-frame:** the frame aborts. `o_tx` is high from the next cycle, with no partial stop bit. Reset overrides acceptance in the same cycle.
- **Latency:** `o_tx` falls on the first cycle after the accepting edge, because `o_tx` is registered from the next-state value.
- **Bit duration:** every bit holds exactly CLOCKS_PER_BIT cycles.
- **Frame length:** (DATA_WIDTH+2)×CLOCKS_PER_BIT cycles, counted from the first low `o_tx` cycle to the last stop cycle inclusive.
- **Frame spacing:** with back-to-back acceptance, the next start bit directly follows the last stop cycle, with zero idle cycles. Without it, `o_tx` stays high in IDLE until the next acceptance.
- **`o_done`:** high for exactly one cycle per completed frame, coincident with the last stop cycle. It is never asserted for an aborted frame.
- **`o_busy`:** high from the first START cycle through the last STOP cycle.

## Structure
- **Shared constants file:** FSM state encodings (2-bit localparams, one per state) and frame constants (start level 0, stop level 1, idle level 1). These are shared with the receiver so both ends agree on the frame format.
- **Sub-module `transmitter_bit_counter`:** holds the bit index.
  - Inputs: clear, advance.
  - Output: `o_equal_MSB`.
  - This mirrors the receiver-side bit counter.
- **Kept in the top:** baud counter, shift register and FSM.

## Test plan
All scenarios use DATA_WIDTH=8 and CLOCKS_PER_BIT=4.
- **Reset:** hold `i_resetL`=0 for 3 cycles -> `o_tx`=1, `o_ready`=1, `o_busy`=0, `o_done`=0.
- **Single frame 0x55:** send 0x55 -> `o_tx` carries 0, then 1,0,1,0,1,0,1,0, then 1, each bit held 4 cycles, 40 cycles total. `o_done` pulses once on cycle 40, and `o_ready` is high on cycle 40.
- **Back-to-back 0xA5 then 0x3C:** `i_valid` held continuously -> the second start bit begins the cycle after the first stop ends, and `o_done` pulses exactly twice, 40 cycles apart.
- **Valid while busy:** present 0xFF with `i_valid` during the DATA of frame 0x0F -> ignored, and the line shows only the 0x0F frame.
- **Reset at cycle 17 of frame 0x81:** `o_tx`=1 from the next cycle and `o_done` never pulses. A subsequent send of 0x81 yields a correct 40-cycle frame.
- **`i_data` changes after acceptance:** `i_data` toggles every cycle after 0xC3 is accepted -> the serialized bits still equal 0xC3, LSB first.
